fetch_stage: RTL

- Instruction fetch stage of the RISC-V core: owns the PC, issues requests to instruction memory and buffers returned words.
- Presents each instruction with its PC to the decode stage. id_instruction drives the immediate generator's Instruction input directly.
- Handles decode back-pressure and branch/jump redirects, including discarding stale in-flight fetches.

---
 rtl/fetch_stage.sv | 75 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues instruction fetches, buffers returned words and presents them to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction
);
  logic [31:0] pc;
  logic [1:0]  outst, drop, cnt;
  logic [31:0] aq [2];
  logic [31:0] fpc [2];
  logic [31:0] fins [2];
  logic        aq_wr, aq_rd, f_wr, f_rd;
  logic        fire, rsp, push, pop;
  // Credit rule: outstanding plus buffered never exceeds the FIFO depth
  always_comb begin
    imem_req_valid = reset && !redirect_valid && ({1'b0, outst} + {1'b0, cnt} < 3'd2);
    imem_req_addr  = pc;
    fire           = imem_req_valid && imem_req_ready;
    rsp            = imem_rsp_valid && outst != 2'd0;
    push           = rsp && drop == 2'd0 && !redirect_valid;
    id_valid       = cnt != 2'd0 && !redirect_valid;
    pop            = id_valid && id_ready;
    id_pc          = id_valid ? fpc[f_rd] : 32'd0;
    id_instruction = id_valid ? fins[f_rd] : NOP_INSN;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      outst <= 2'd0;
      drop  <= 2'd0;
      cnt   <= 2'd0;
      aq_wr <= 1'b0;
      aq_rd <= 1'b0;
      f_wr  <= 1'b0;
      f_rd  <= 1'b0;
    end else begin
      if (fire) aq_wr <= !aq_wr;
      if (rsp) aq_rd <= !aq_rd;
      outst <= outst + {1'b0, fire} - {1'b0, rsp};
      if (redirect_valid) begin
        pc   <= redirect_pc & 32'hFFFF_FFFC;
        cnt  <= 2'd0;
        f_wr <= 1'b0;
        f_rd <= 1'b0;
        drop <= outst - {1'b0, rsp};
      end else begin
        if (fire) pc <= pc + 32'd4;
        if (rsp && drop != 2'd0) drop <= drop - 2'd1;
        if (push) f_wr <= !f_wr;
        if (pop) f_rd <= !f_rd;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (fire) aq[aq_wr] <= pc;
    if (push) begin
      fpc[f_wr]  <= aq[aq_rd];
      fins[f_wr] <= imem_rsp_data;
    end
  end
endmodule
